fifo_rd_axis: RTL and testbench



---
 rtl/fifo_rd_axis.sv | 140 ++++++++++++++
 tb/tb_fifo_rd_axis.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_axis.sv
// FWFT FIFO read port to AXI4-Stream master through a 2-entry skid buffer, with packet flush.
// Define FIFO_RD_AXIS_STATS_EN to add the BEAT_CNT / PKT_CNT / DROP_CNT counters.
module fifo_rd_axis #(
    parameter int DATA_W   = 64,
    parameter int LAST_BIT = 0
) (
    input  logic              RDCLK,
    input  logic              RST,
    input  logic              RDRSTBUSY,
    input  logic              EMPTY,
    input  logic [DATA_W-1:0] DOUT,
    input  logic [7:0]        DOUTP,
    output logic              RDEN,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    input  logic              FLUSH,
    output logic              FLUSH_BUSY
`ifdef FIFO_RD_AXIS_STATS_EN
    ,
    output logic [31:0]       BEAT_CNT,
    output logic [31:0]       PKT_CNT,
    output logic [31:0]       DROP_CNT
`endif
);

    typedef enum logic [1:0] {StWaitRst, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [1:0]        buf_last_q;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              tvalid, pop, rden, in_last;
    logic              rem_ptr;
    logic [1:0]        rem;
    logic [1:0]        drop_n;

    assign in_last = DOUTP[LAST_BIT];

    always_comb begin
        tvalid  = !RST && (state_q == StRun) && (occ_q != 2'd0);
        pop     = tvalid && M_AXIS_TREADY;
        // Head of what is left once this cycle's handshake is accounted for.
        rem_ptr = rptr_q ^ pop;
        rem     = occ_q - {1'b0, pop};
        rden    = 1'b0;
        drop_n  = 2'd0;
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q;
        case (state_q)
            StWaitRst: begin
                if (!RDRSTBUSY) state_d = StRun;
            end
            StRun: begin
                if (FLUSH) begin
                    if (rem != 2'd0 && buf_last_q[rem_ptr]) begin
                        rptr_d = ~rem_ptr;
                        occ_d  = rem - 2'd1;
                        drop_n = 2'd1;
                    end else if (rem == 2'd2 && buf_last_q[~rem_ptr]) begin
                        rptr_d = rem_ptr;
                        occ_d  = 2'd0;
                        drop_n = 2'd2;
                    end else begin
                        rptr_d  = wptr_q;
                        occ_d   = 2'd0;
                        drop_n  = rem;
                        state_d = StDrain;
                    end
                end else begin
                    rden   = !EMPTY && !RDRSTBUSY && (occ_q != 2'd2);
                    occ_d  = occ_q + {1'b0, rden} - {1'b0, pop};
                    rptr_d = rptr_q ^ pop;
                    wptr_d = wptr_q ^ rden;
                end
            end
            StDrain: begin
                rden = !EMPTY && !RDRSTBUSY;
                if (rden) begin
                    drop_n = 2'd1;
                    if (in_last) state_d = StRun;
                end
            end
            default: state_d = StWaitRst;
        endcase
        if (RST) rden = 1'b0;
    end

    always_ff @(posedge RDCLK) begin
        if (RST) begin
            state_q    <= StWaitRst;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            occ_q      <= 2'd0;
            buf_last_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            if (rden && state_q == StRun) buf_last_q[wptr_q] <= in_last;
        end
    end

    always_ff @(posedge RDCLK) begin
        if (rden && state_q == StRun) buf_data_q[wptr_q] <= DOUT;
    end

    assign RDEN          = rden;
    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = tvalid ? buf_data_q[rptr_q] : '0;
    assign M_AXIS_TLAST  = tvalid && buf_last_q[rptr_q];
    assign FLUSH_BUSY    = RST || (state_q != StRun);

`ifdef FIFO_RD_AXIS_STATS_EN
    always_ff @(posedge RDCLK) begin
        if (RST) begin
            BEAT_CNT <= 32'd0;
            PKT_CNT  <= 32'd0;
            DROP_CNT <= 32'd0;
        end else begin
            BEAT_CNT <= BEAT_CNT + {31'd0, pop};
            PKT_CNT  <= PKT_CNT + {31'd0, pop && M_AXIS_TLAST};
            DROP_CNT <= DROP_CNT + {30'd0, drop_n};
        end
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop_n;
`endif

    logic unused_doutp;
    assign unused_doutp = ^DOUTP;

endmodule

// File: tb/tb_fifo_rd_axis.sv
// Bench for fifo_rd_axis: queue-based FIFO and buffer model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_fifo_rd_axis;
    localparam int DW = 64;
    localparam int LB = 5;

    logic          RDCLK = 1'b0;
    logic          RST, RDRSTBUSY, EMPTY, RDEN;
    logic [DW-1:0] DOUT, M_AXIS_TDATA;
    logic [7:0]    DOUTP;
    logic          M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY, FLUSH, FLUSH_BUSY;
`ifdef FIFO_RD_AXIS_STATS_EN
    logic [31:0]   BEAT_CNT, PKT_CNT, DROP_CNT;
`endif

    always #5 RDCLK = ~RDCLK;

    fifo_rd_axis #(.DATA_W(DW), .LAST_BIT(LB)) dut (
        .RDCLK(RDCLK), .RST(RST), .RDRSTBUSY(RDRSTBUSY), .EMPTY(EMPTY), .DOUT(DOUT),
        .DOUTP(DOUTP), .RDEN(RDEN), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .FLUSH(FLUSH),
        .FLUSH_BUSY(FLUSH_BUSY)
`ifdef FIFO_RD_AXIS_STATS_EN
        , .BEAT_CNT(BEAT_CNT), .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
`endif
    );

    typedef struct packed {logic [DW-1:0] d; logic l;} ent_t;
    typedef enum int {MWait, MRun, MDrain} mode_e;

    ent_t          fifo[$];
    ent_t          pend[$];
    ent_t          mbuf[$];
    logic [DW-1:0] got[$];
    logic          got_last[$];
    int            got_cyc[$];
    mode_e         mode;
    logic [31:0]   mbeat, mpkt, mdrop;
    int            checks = 0, errors = 0, cyc = 0;
    int            fill_pct = 100;
    logic          rst_v, busy_v, tready_v, flush_v, tready_rand, flush_rand;
    logic          obs_rden, obs_tvalid, obs_fb;
    logic [DW-1:0] obs_tdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare at +1, advance the model at posedge.
    task automatic step();
        logic          e_tv, e_rd, e_fb, e_hs, e_tl;
        logic [DW-1:0] e_td;
        if (pend.size() > 0 && $urandom_range(0, 99) < fill_pct)
            fifo.push_back(pend.pop_front());
        RST       = rst_v;
        RDRSTBUSY = busy_v;
        FLUSH     = flush_rand ? ($urandom_range(0, 19) == 0) : flush_v;
        M_AXIS_TREADY = tready_rand ? 1'($urandom_range(0, 1)) : tready_v;
        EMPTY = (fifo.size() == 0);
        DOUTP = 8'($urandom);
        if (fifo.size() > 0) begin
            DOUT      = fifo[0].d;
            DOUTP[LB] = fifo[0].l;
        end else begin
            DOUT = {$urandom, $urandom};
        end
        #1;
        e_tv = !RST && mode == MRun && mbuf.size() > 0;
        e_td = e_tv ? mbuf[0].d : '0;
        e_tl = e_tv && mbuf[0].l;
        e_rd = !RST && !EMPTY && !RDRSTBUSY &&
               ((mode == MRun && mbuf.size() < 2 && !FLUSH) || mode == MDrain);
        e_fb = RST || mode != MRun;
        chk("rden", RDEN, e_rd);
        chk("tvalid", M_AXIS_TVALID, e_tv);
        chk("tdata", M_AXIS_TDATA, e_td);
        chk("tlast", M_AXIS_TLAST, e_tl);
        chk("flush_busy", FLUSH_BUSY, e_fb);
        if (EMPTY) chk("rden_while_empty", RDEN, 1'b0);
`ifdef FIFO_RD_AXIS_STATS_EN
        chk("beat_cnt", BEAT_CNT, mbeat);
        chk("pkt_cnt", PKT_CNT, mpkt);
        chk("drop_cnt", DROP_CNT, mdrop);
`endif
        obs_rden   = RDEN;
        obs_tvalid = M_AXIS_TVALID;
        obs_fb     = FLUSH_BUSY;
        obs_tdata  = M_AXIS_TDATA;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            got.push_back(M_AXIS_TDATA);
            got_last.push_back(M_AXIS_TLAST);
            got_cyc.push_back(cyc);
        end
        e_hs = e_tv && M_AXIS_TREADY;
        @(posedge RDCLK);
        if (RST) begin
            mode = MWait;
            mbuf.delete();
            mbeat = 0; mpkt = 0; mdrop = 0;
        end else begin
            case (mode)
                MWait: if (!RDRSTBUSY) mode = MRun;
                MRun: begin
                    if (e_hs) begin
                        mbeat++;
                        if (mbuf[0].l) mpkt++;
                        void'(mbuf.pop_front());
                    end
                    if (FLUSH) begin
                        if (mbuf.size() >= 1 && mbuf[0].l) begin
                            void'(mbuf.pop_front());
                            mdrop += 1;
                        end else if (mbuf.size() == 2 && mbuf[1].l) begin
                            mbuf.delete();
                            mdrop += 2;
                        end else begin
                            mdrop += 32'(mbuf.size());
                            mbuf.delete();
                            mode = MDrain;
                        end
                    end else if (e_rd) begin
                        mbuf.push_back(fifo[0]);
                    end
                end
                MDrain: if (e_rd) begin
                    mdrop++;
                    if (fifo[0].l) mode = MRun;
                end
                default: mode = MWait;
            endcase
        end
        if (e_rd) void'(fifo.pop_front());
        cyc++;
        @(negedge RDCLK);
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(nm, got.size() >= n, 1'b1);
    endtask

    task automatic clear_got();
        got.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [DW-1:0] base;
        int            nbad, nlast, rden_seen, fb_seen;
        ent_t          e;
        base = 64'hFEDCBA98_76543210;
        rst_v = 1; busy_v = 1; tready_v = 1; flush_v = 0; tready_rand = 0; flush_rand = 0;
        mode = MWait; mbeat = 0; mpkt = 0; mdrop = 0;
        RST = 1; RDRSTBUSY = 1; EMPTY = 1; DOUT = '0; DOUTP = '0;
        M_AXIS_TREADY = 1; FLUSH = 0;
        @(posedge RDCLK);
        @(negedge RDCLK);

        // Reset state and read-reset hold-off
        for (int i = 0; i < 512; i++) fifo.push_back('{d: base + DW'(i), l: (i == 511)});
        step();
        chk("rst_tvalid", obs_tvalid, 1'b0);
        chk("rst_rden", obs_rden, 1'b0);
        chk("rst_tdata", obs_tdata, '0);
        chk("rst_fb", obs_fb, 1'b1);
        rst_v = 0;
        rden_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            rden_seen += int'(obs_rden);
        end
        chk("busy_rden_cnt", rden_seen, 0);
        busy_v = 0;
        step();
        chk("busy_release_fb", obs_fb, 1'b1);
        step();
        chk("run_fb", obs_fb, 1'b0);
        chk("run_first_rden", obs_rden, 1'b1);
        chk("run_first_tvalid", obs_tvalid, 1'b0);
        step();
        chk("first_beat_tvalid", obs_tvalid, 1'b1);
        chk("first_beat_tdata", obs_tdata, base);

        // Full-rate 512-word stream
        run_until(512, 700, "stream_timeout");
        nbad = 0; nlast = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== base + DW'(i)) nbad++;
            if (got_last[i]) nlast++;
        end
        chk("stream_order", nbad, 0);
        chk("stream_count", got.size(), 512);
        chk("stream_nlast", nlast, 1);
        chk("stream_final_last", got_last[511], 1'b1);
        chk("stream_gapless", got_cyc[511] - got_cyc[0], 511);

        // Same stream with random TREADY and random FIFO gaps
        clear_got();
        rst_v = 1; step(); rst_v = 0;
        for (int i = 0; i < 512; i++) pend.push_back('{d: base + DW'(i), l: (i == 511)});
        fill_pct = 60; tready_rand = 1;
        run_until(512, 6000, "rand_timeout");
        nbad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== base + DW'(i)) nbad++;
        chk("rand_order", nbad, 0);
        chk("rand_count", got.size(), 512);
        tready_rand = 0; fill_pct = 100; tready_v = 1;
        for (int i = 0; i < 4; i++) step();

        // Flush mid-packet: rest of packet 0 dropped through DRAIN
        clear_got();
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++) fifo.push_back('{d: DW'(256 + p * 16 + b), l: (b == 3)});
        run_until(2, 20, "pkt_b1_timeout");
        chk("pkt_b1_data", got[1], DW'(257));
        flush_v = 1; tready_v = 0; step();
        flush_v = 0; tready_v = 1;
        fb_seen = 0;
        while (got.size() < 3 && fb_seen < 40) begin
            step();
            fb_seen += int'(obs_fb);
        end
        chk("pkt_fb_in_drain", fb_seen != 0 && fb_seen < 40, 1'b1);
        chk("pkt_next_beat", got[2], DW'(272));
        run_until(10, 30, "pkt_tail_timeout");
        chk("pkt_tail_data", got[9], DW'(291));

        // Flush with head last=1 and next packet behind it: only head dropped
        clear_got();
        fifo.push_back('{d: DW'(512), l: 1'b0});
        fifo.push_back('{d: DW'(513), l: 1'b1});
        fifo.push_back('{d: DW'(768), l: 1'b0});
        fifo.push_back('{d: DW'(769), l: 1'b1});
        run_until(1, 20, "hdl_timeout");
        tready_v = 0;
        for (int i = 0; i < 3; i++) step();
        flush_v = 1; step(); flush_v = 0;
        chk("hdl_fb_flush", obs_fb, 1'b0);
        step();
        chk("hdl_fb_after", obs_fb, 1'b0);
        tready_v = 1;
        run_until(3, 20, "hdl_next_timeout");
        chk("hdl_next0", got[1], DW'(768));
        chk("hdl_next1", got[2], DW'(769));

        // Reset mid-stream with a full buffer
        for (int i = 0; i < 6; i++) fifo.push_back('{d: DW'(1024 + i), l: 1'b0});
        tready_v = 0;
        for (int i = 0; i < 4; i++) step();
        rst_v = 1; step(); rst_v = 0; busy_v = 1;
        step();
        chk("rstmid_tvalid", obs_tvalid, 1'b0);
        chk("rstmid_rden", obs_rden, 1'b0);
        chk("rstmid_fb", obs_fb, 1'b1);
`ifdef FIFO_RD_AXIS_STATS_EN
        chk("rstmid_beat_cnt", BEAT_CNT, 32'd0);
        chk("rstmid_pkt_cnt", PKT_CNT, 32'd0);
        chk("rstmid_drop_cnt", DROP_CNT, 32'd0);
`endif
        busy_v = 0; tready_v = 1;
        for (int i = 0; i < 10; i++) step();

        // Random packets, random TREADY, random FLUSH and read-reset blips
        fill_pct = 70; tready_rand = 1; flush_rand = 1;
        for (int p = 0; p < 60; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                e.d = {$urandom, $urandom};
                e.l = (b == len - 1);
                pend.push_back(e);
            end
        end
        for (int i = 0; i < 600; i++) begin
            busy_v = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
